lio_i8080_host_ctrl: RTL and testbench

- Synthesizable i8080-style parallel bus initiator (host side) for driving an LCD/display controller.
- Accepts command/data write and read requests on a valid/ready interface.
- Generates ce_n/dc/wr_n/rd_n strobes with parameterised cycle timing.
- Returns read data on a one-cycle response pulse. The tri-state bus is split into d_o/d_oe/d_i; the top level owns the pad buffer.

---
 rtl/lio_i8080_host_ctrl.sv | 142 ++++++++++++++
 tb/tb_lio_i8080_host_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lio_i8080_host_ctrl.sv
// rtl/lio_i8080_host_ctrl.sv - i8080-style parallel bus host controller for display panels
// One request per SETUP/STROBE/HOLD sequence; the pad buffer for d_o/d_oe/d_i lives above this block.
module lio_i8080_host_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int SETUP_CYC   = 1,
    parameter int WR_LOW_CYC  = 2,
    parameter int WR_HIGH_CYC = 2,
    parameter int RD_LOW_CYC  = 3,
    parameter int RD_HIGH_CYC = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_rnw,
    input  logic                  req_dc,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy,
    output logic                  ce_n,
    output logic                  dc,
    output logic                  wr_n,
    output logic                  rd_n,
    output logic [DATA_WIDTH-1:0] d_o,
    output logic                  d_oe,
    input  logic [DATA_WIDTH-1:0] d_i
);

    if (SETUP_CYC < 1 || SETUP_CYC > 255 || WR_LOW_CYC < 1 || WR_LOW_CYC > 255 ||
        WR_HIGH_CYC < 1 || WR_HIGH_CYC > 255 || RD_LOW_CYC < 1 || RD_LOW_CYC > 255 ||
        RD_HIGH_CYC < 1 || RD_HIGH_CYC > 255) begin : g_bad_timing
        $error("lio_i8080_host_ctrl: timing parameters must lie in 1..255");
    end

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

    localparam logic [7:0] SETUP_LAST   = 8'(SETUP_CYC - 1);
    localparam logic [7:0] WR_LOW_LAST  = 8'(WR_LOW_CYC - 1);
    localparam logic [7:0] WR_HIGH_LAST = 8'(WR_HIGH_CYC - 1);
    localparam logic [7:0] RD_LOW_LAST  = 8'(RD_LOW_CYC - 1);
    localparam logic [7:0] RD_HIGH_LAST = 8'(RD_HIGH_CYC - 1);

    state_t                r_state;
    logic [7:0]            r_cnt;
    logic                  r_rnw;
    logic                  r_ce_n;
    logic                  r_dc;
    logic                  r_wr_n;
    logic                  r_rd_n;
    logic [DATA_WIDTH-1:0] r_d_o;
    logic                  r_d_oe;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;

    logic [7:0] w_low_last;
    logic [7:0] w_high_last;
    logic       w_accept;

    assign w_low_last  = r_rnw ? RD_LOW_LAST : WR_LOW_LAST;
    assign w_high_last = r_rnw ? RD_HIGH_LAST : WR_HIGH_LAST;
    assign req_ready   = (r_state == S_IDLE) || (r_state == S_HOLD && r_cnt == w_high_last);
    assign w_accept    = req_valid && req_ready;
    assign busy        = (r_state != S_IDLE);

    assign ce_n      = r_ce_n;
    assign dc        = r_dc;
    assign wr_n      = r_wr_n;
    assign rd_n      = r_rd_n;
    assign d_o       = r_d_o;
    assign d_oe      = r_d_oe;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_rnw       <= 1'b0;
            r_ce_n      <= 1'b1;
            r_dc        <= 1'b0;
            r_wr_n      <= 1'b1;
            r_rd_n      <= 1'b1;
            r_d_o       <= '0;
            r_d_oe      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            // Accept only happens in IDLE or the last HOLD cycle; ce_n stays low on a back-to-back accept.
            if (w_accept) begin
                r_state <= S_SETUP;
                r_cnt   <= 8'd0;
                r_rnw   <= req_rnw;
                r_ce_n  <= 1'b0;
                r_dc    <= req_dc;
                r_d_oe  <= !req_rnw;
                if (!req_rnw) begin
                    r_d_o <= req_wdata;
                end
            end else begin
                case (r_state)
                    S_SETUP: begin
                        if (r_cnt == SETUP_LAST) begin
                            r_state <= S_STROBE;
                            r_cnt   <= 8'd0;
                            r_wr_n  <= r_rnw;
                            r_rd_n  <= !r_rnw;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    S_STROBE: begin
                        if (r_cnt == w_low_last) begin
                            r_state <= S_HOLD;
                            r_cnt   <= 8'd0;
                            r_wr_n  <= 1'b1;
                            r_rd_n  <= 1'b1;
                            if (r_rnw) begin
                                r_rsp_rdata <= d_i;
                                r_rsp_valid <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    S_HOLD: begin
                        if (r_cnt == w_high_last) begin
                            r_state <= S_IDLE;
                            r_ce_n  <= 1'b1;
                            r_d_oe  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lio_i8080_host_ctrl.sv
// tb/tb_lio_i8080_host_ctrl.sv - directed bench for lio_i8080_host_ctrl with a small display model
module tb_lio_i8080_host_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_rnw, req_dc;
    logic [7:0] req_wdata, rsp_rdata, d_o, d_i;
    logic       rsp_valid, busy, ce_n, dc, wr_n, rd_n, d_oe;

    logic       t2_req_valid, t2_req_ready, t2_req_rnw, t2_req_dc;
    logic [7:0] t2_req_wdata, t2_rsp_rdata, t2_d_o, t2_d_i;
    logic       t2_rsp_valid, t2_busy, t2_ce_n, t2_dc, t2_wr_n, t2_rd_n, t2_d_oe;

    int total = 0;
    int bad   = 0;
    int viol  = 0;

    always #5 clk = ~clk;

    lio_i8080_host_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_rnw(req_rnw), .req_dc(req_dc), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .ce_n(ce_n), .dc(dc), .wr_n(wr_n), .rd_n(rd_n),
        .d_o(d_o), .d_oe(d_oe), .d_i(d_i)
    );

    lio_i8080_host_ctrl #(.SETUP_CYC(3), .RD_LOW_CYC(5), .RD_HIGH_CYC(1)) dut2 (
        .clk(clk), .rst(rst), .req_valid(t2_req_valid), .req_ready(t2_req_ready),
        .req_rnw(t2_req_rnw), .req_dc(t2_req_dc), .req_wdata(t2_req_wdata),
        .rsp_valid(t2_rsp_valid), .rsp_rdata(t2_rsp_rdata), .busy(t2_busy),
        .ce_n(t2_ce_n), .dc(t2_dc), .wr_n(t2_wr_n), .rd_n(t2_rd_n),
        .d_o(t2_d_o), .d_oe(t2_d_oe), .d_i(t2_d_i)
    );

    // Display model: cmd 0x1C opens memory write, 0x1D opens memory read; otherwise reads return 0xEB.
    logic [7:0] m_cmd = 8'h00;
    logic [7:0] m_mem [0:15];
    logic [3:0] m_wptr = 4'd0;
    logic [3:0] m_rptr = 4'd0;

    assign d_i    = (m_cmd == 8'h1D) ? m_mem[m_rptr] : 8'hEB;
    assign t2_d_i = 8'h5A;

    always @(posedge wr_n) begin
        if (ce_n === 1'b0) begin
            if (dc === 1'b0) begin
                m_cmd  = d_o;
                m_wptr = 4'd0;
                m_rptr = 4'd0;
            end else if (m_cmd == 8'h1C) begin
                m_mem[m_wptr] = d_o;
                m_wptr        = m_wptr + 4'd1;
            end
        end
    end

    always @(posedge rd_n) begin
        if (ce_n === 1'b0) m_rptr = m_rptr + 4'd1;
    end

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (d_oe === 1'b1 && rd_n === 1'b0) viol++;
            if (wr_n === 1'b0 && rd_n === 1'b0) viol++;
            if (ce_n === 1'b1 && (wr_n === 1'b0 || rd_n === 1'b0)) viol++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic rnw, input logic dcv, input logic [7:0] wd);
        int n;
        req_rnw = rnw; req_dc = dcv; req_wdata = wd; req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_timeout: req_ready=%b after %0d cycles, required 1", req_ready, n);
        end else begin
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 50) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_rnw = 1'b0; req_dc = 1'b0; req_wdata = 8'h00;
        t2_req_valid = 1'b0; t2_req_rnw = 1'b0; t2_req_dc = 1'b0; t2_req_wdata = 8'h00;
        #1;
        total++;
        if ({ce_n, wr_n, rd_n, dc, d_oe, rsp_valid, busy, req_ready} !== 8'b1110_0001) begin
            bad++;
            $display("FAIL reset_ctrl: {ce_n,wr_n,rd_n,dc,d_oe,rsp_valid,busy,ready}=%b required 11100001",
                     {ce_n, wr_n, rd_n, dc, d_oe, rsp_valid, busy, req_ready});
        end
        total++;
        if (d_o !== 8'h00 || rsp_rdata !== 8'h00) begin
            bad++;
            $display("FAIL reset_data: d_o=%h rsp_rdata=%h required 00 00", d_o, rsp_rdata);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: ready=%b busy=%b required 1 0", req_ready, busy);
        end
    endtask

    task automatic test_single_write();
        logic [5:0] w, c, oe, rdy, bz;
        logic [7:0] dob;
        logic       dcb;
        wait_idle();
        send(1'b0, 1'b0, 8'h2C);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            w[i] = wr_n; c[i] = ce_n; oe[i] = d_oe; rdy[i] = req_ready; bz[i] = busy;
            if (i == 1) begin dob = d_o; dcb = dc; end
        end
        total++;
        if (w !== 6'b111001) begin bad++; $display("FAIL sw_wr_n: trace=%b required 111001", w); end
        total++;
        if (c !== 6'b100000) begin bad++; $display("FAIL sw_ce_n: trace=%b required 100000", c); end
        total++;
        if (oe !== 6'b011111) begin bad++; $display("FAIL sw_d_oe: trace=%b required 011111", oe); end
        total++;
        if (rdy !== 6'b110000) begin bad++; $display("FAIL sw_ready: trace=%b required 110000", rdy); end
        total++;
        if (bz !== 6'b011111) begin bad++; $display("FAIL sw_busy: trace=%b required 011111", bz); end
        total++;
        if (dob !== 8'h2C || dcb !== 1'b0) begin
            bad++; $display("FAIL sw_bus: d_o=%h dc=%b required 2c 0", dob, dcb);
        end
    endtask

    task automatic test_readback();
        int n;
        logic [7:0] exp_d;
        wait_idle();
        send(1'b0, 1'b0, 8'h1C);
        send(1'b0, 1'b1, 8'hA5);
        send(1'b0, 1'b1, 8'h3C);
        send(1'b0, 1'b0, 8'h1D);
        for (int r = 0; r < 2; r++) begin
            exp_d = (r == 0) ? 8'hA5 : 8'h3C;
            send(1'b1, 1'b1, 8'h00);
            n = 0;
            while (n < 20) begin
                @(posedge clk); #1; n++;
                if (rsp_valid === 1'b1) break;
            end
            total++;
            if (n != 4 || rsp_valid !== 1'b1) begin
                bad++; $display("FAIL rb_latency%0d: rsp_valid after %0d edges, required 4", r, n);
            end
            total++;
            if (rsp_rdata !== exp_d) begin
                bad++; $display("FAIL rb_data%0d: rsp_rdata=%h required %h", r, rsp_rdata, exp_d);
            end
            @(posedge clk); #1;
            total++;
            if (rsp_valid !== 1'b0) begin
                bad++; $display("FAIL rb_pulse%0d: rsp_valid=%b in second HOLD cycle, required 0", r, rsp_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc;
        int acc_cyc [4];
        logic rdy;
        logic [2:0] got, exp_v;
        logic [7:0] exp_d;
        wait_idle();
        req_rnw = 1'b0; req_dc = 1'b1; req_wdata = 8'h01; req_valid = 1'b1;
        acc = 0;
        for (int cy = 0; cy <= 20; cy++) begin
            rdy = req_ready;
            @(posedge clk); #1;
            if (rdy && req_valid) begin
                acc_cyc[acc] = cy;
                acc++;
                if (acc == 4) req_valid = 1'b0;
                else req_wdata = 8'(acc + 1);
            end
            got   = {ce_n, wr_n, req_ready};
            exp_v = (cy == 20) ? 3'b111 :
                    {1'b0, !((cy % 5) == 1 || (cy % 5) == 2), (cy % 5) == 4};
            total++;
            if (got !== exp_v) begin
                bad++; $display("FAIL b2b_cycle%0d: {ce_n,wr_n,ready}=%b required %b", cy, got, exp_v);
            end
            if (cy < 20 && (cy % 5) == 1) begin
                exp_d = 8'(cy / 5 + 1);
                total++;
                if (d_o !== exp_d) begin
                    bad++; $display("FAIL b2b_data%0d: d_o=%h required %h", cy, d_o, exp_d);
                end
            end
        end
        req_valid = 1'b0;
        total++;
        if (acc != 4) begin
            bad++; $display("FAIL b2b_count: accepted=%0d required 4", acc);
        end else begin
            for (int j = 0; j < 4; j++) begin
                total++;
                if (acc_cyc[j] != 5 * j) begin
                    bad++; $display("FAIL b2b_accept%0d: cycle=%0d required %0d", j, acc_cyc[j], 5 * j);
                end
            end
        end
    endtask

    task automatic test_turnaround();
        int n;
        wait_idle();
        send(1'b0, 1'b0, 8'h55);
        send(1'b1, 1'b1, 8'h00);
        total++;
        if (d_oe !== 1'b0 || ce_n !== 1'b0 || rd_n !== 1'b1) begin
            bad++; $display("FAIL ta_setup: d_oe=%b ce_n=%b rd_n=%b required 0 0 1", d_oe, ce_n, rd_n);
        end
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1; n++;
            if (rsp_valid === 1'b1) break;
        end
        total++;
        if (n != 4 || rsp_rdata !== 8'hEB) begin
            bad++; $display("FAIL ta_read: edges=%0d rsp_rdata=%h required 4 eb", n, rsp_rdata);
        end
    endtask

    task automatic test_timing();
        logic [9:0] rdt, rdy, cet, rv;
        logic [7:0] rdat;
        int n;
        t2_req_rnw = 1'b1; t2_req_dc = 1'b1; t2_req_valid = 1'b1;
        for (int s = 0; s < 10; s++) begin
            @(posedge clk); #1;
            rdt[s] = t2_rd_n; rdy[s] = t2_req_ready; cet[s] = t2_ce_n; rv[s] = t2_rsp_valid;
            if (s == 8) rdat = t2_rsp_rdata;
        end
        t2_req_valid = 1'b0;
        total++;
        if (rdt !== 10'b1100000111) begin bad++; $display("FAIL tp_rd_n: trace=%b required 1100000111", rdt); end
        total++;
        if (rdy !== 10'b0100000000) begin bad++; $display("FAIL tp_ready: trace=%b required 0100000000", rdy); end
        total++;
        if (cet !== 10'b0000000000) begin bad++; $display("FAIL tp_ce_n: trace=%b required 0000000000", cet); end
        total++;
        if (rv !== 10'b0100000000 || rdat !== 8'h5A) begin
            bad++; $display("FAIL tp_rsp: valid=%b data=%h required 0100000000 5a", rv, rdat);
        end
        n = 0;
        while (t2_busy !== 1'b0 && n < 30) begin @(posedge clk); #1; n++; end
        total++;
        if (t2_busy !== 1'b0 || t2_ce_n !== 1'b1) begin
            bad++; $display("FAIL tp_idle: busy=%b ce_n=%b required 0 1", t2_busy, t2_ce_n);
        end
    endtask

    task automatic test_reset_mid_read();
        int n, seen;
        wait_idle();
        send(1'b1, 1'b1, 8'h00);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        total++;
        if ({ce_n, rd_n, wr_n, d_oe, busy} !== 5'b11100) begin
            bad++; $display("FAIL rst_mid: {ce_n,rd_n,wr_n,d_oe,busy}=%b required 11100", {ce_n, rd_n, wr_n, d_oe, busy});
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (rsp_valid === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL rst_no_rsp: rsp_valid pulses=%0d required 0", seen); end
        send(1'b1, 1'b1, 8'h00);
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1; n++;
            if (rsp_valid === 1'b1) break;
        end
        total++;
        if (n != 4 || rsp_rdata !== 8'hEB) begin
            bad++; $display("FAIL rst_next: edges=%0d rsp_rdata=%h required 4 eb", n, rsp_rdata);
        end
        wait_idle();
        total++;
        if (busy !== 1'b0 || ce_n !== 1'b1) begin
            bad++; $display("FAIL rst_idle: busy=%b ce_n=%b required 0 1", busy, ce_n);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_readback();
        test_back_to_back();
        test_turnaround();
        test_timing();
        test_reset_mid_read();
        total++;
        if (viol != 0) begin bad++; $display("FAIL bus_rules: violations=%0d required 0", viol); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
